pwm_deadtime_mc: RTL

- Multi-channel complementary PWM generator with programmable dead-time insertion. It is the parametrised successor of the single-output pwm_gen.
- One shared up-counter sets the carrier period. Each channel compares the counter against its own duty value and drives a high-side/low-side output pair with break-before-make gaps.
- Period, duties and dead-time are double-buffered and take effect only at a period boundary, so a configuration change never produces a glitch mid-period.
- Sits between the control/register logic and the gate-driver pins.

---
 rtl/pwm_deadtime_mc_if.sv | 41 ++++
 rtl/pwm_deadtime_mc.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pwm_deadtime_mc_if.sv
// ---------------------------------------------------------------------------
// pwm_deadtime_mc_if
// Bundle between the control/register side and the complementary PWM block.
//
// Signals:
//   en          run enable; 0 forces the block idle
//   cfg_load    single-cycle strobe capturing period_in/duty_in/dt_in
//   period_in   terminal count (period = period_in + 1 cycles)
//   duty_in     per-channel duty, channel i at [i*CNT_W +: CNT_W]
//   dt_in       shared dead-time in clock cycles
//   pwm_h/pwm_l high-side / low-side gate outputs, one bit per channel
//   period_end  one-cycle pulse coinciding with counter value 0
//
// Transfer semantics: cfg_load is a plain strobe with no ready/valid pair.
// Every cycle with cfg_load=1 is accepted unconditionally and overwrites the
// pending configuration; there is no back-pressure. Outputs are registered.
// ---------------------------------------------------------------------------
interface pwm_deadtime_mc_if #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 16,
  parameter int DT_W  = 8
);
  logic                    en;
  logic                    cfg_load;
  logic [CNT_W-1:0]        period_in;
  logic [N_CH*CNT_W-1:0]   duty_in;
  logic [DT_W-1:0]         dt_in;
  logic [N_CH-1:0]         pwm_h;
  logic [N_CH-1:0]         pwm_l;
  logic                    period_end;

  modport master (
    output en, cfg_load, period_in, duty_in, dt_in,
    input  pwm_h, pwm_l, period_end
  );

  modport slave (
    input  en, cfg_load, period_in, duty_in, dt_in,
    output pwm_h, pwm_l, period_end
  );
endinterface

// File: rtl/pwm_deadtime_mc.sv
// ---------------------------------------------------------------------------
// pwm_deadtime_mc
// Multi-channel complementary PWM with break-before-make dead-time.
// A shared up-counter defines the carrier; each channel compares it against
// its duty and drives a high/low pair separated by dt_act idle cycles.
// Period, duties and dead-time are double-buffered (pending -> active) and
// only move to active at a wrap or while disabled.
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous reset, active-high; overrides en and cfg_load
//   bus  pwm_deadtime_mc_if.slave (en, cfg_load, period_in, duty_in, dt_in,
//        pwm_h, pwm_l, period_end)
// ---------------------------------------------------------------------------
module pwm_deadtime_mc #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 16,
  parameter int DT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  pwm_deadtime_mc_if.slave bus
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period_pend;
  logic [CNT_W-1:0] r_period_act;
  logic [CNT_W-1:0] r_duty_pend [N_CH];
  logic [CNT_W-1:0] r_duty_act  [N_CH];
  logic [DT_W-1:0]  r_dt_pend;
  logic [DT_W-1:0]  r_dt_act;
  logic [N_CH-1:0]  r_raw_q;
  logic [DT_W-1:0]  r_dtc [N_CH];
  logic [N_CH-1:0]  r_pwm_h;
  logic [N_CH-1:0]  r_pwm_l;
  logic             r_period_end;

  logic             w_wrap;
  logic [N_CH-1:0]  w_raw;
  logic [N_CH-1:0]  w_raw_q_next;
  logic [DT_W-1:0]  w_dtc_next [N_CH];
  logic [N_CH-1:0]  w_h_next;
  logic [N_CH-1:0]  w_l_next;

  assign w_wrap = bus.en && (r_cnt == r_period_act);

  // Outputs are computed from the *next* raw_q/dtc so the outgoing side
  // drops on the very edge that sees the raw change, and the incoming side
  // rises exactly dt_act cycles later. h and l need opposite raw_q values,
  // so they can never be high together.
  always_comb begin
    w_raw        = '0;
    w_raw_q_next = '0;
    w_h_next     = '0;
    w_l_next     = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_dtc_next[i] = '0;
      w_raw[i]      = (r_cnt < r_duty_act[i]);
      if (!bus.en) begin
        w_raw_q_next[i] = 1'b0;
        w_dtc_next[i]   = '0;
      end else if (w_raw[i] != r_raw_q[i]) begin
        // Any edge (even one inside a running gap) restarts the gap, which
        // swallows raw pulses no longer than the dead-time.
        w_raw_q_next[i] = w_raw[i];
        w_dtc_next[i]   = r_dt_act;
      end else begin
        w_raw_q_next[i] = r_raw_q[i];
        w_dtc_next[i]   = (r_dtc[i] != '0) ? (r_dtc[i] - DT_W'(1)) : '0;
      end
      w_h_next[i] = bus.en &  w_raw_q_next[i] & (w_dtc_next[i] == '0);
      w_l_next[i] = bus.en & ~w_raw_q_next[i] & (w_dtc_next[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_period_pend <= '0;
      r_period_act  <= '0;
      r_dt_pend     <= '0;
      r_dt_act      <= '0;
      r_raw_q       <= '0;
      r_pwm_h       <= '0;
      r_pwm_l       <= '0;
      r_period_end  <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_duty_pend[i] <= '0;
        r_duty_act[i]  <= '0;
        r_dtc[i]       <= '0;
      end
    end else begin
      if (bus.cfg_load) begin
        r_period_pend <= bus.period_in;
        r_dt_pend     <= bus.dt_in;
        for (int i = 0; i < N_CH; i++) begin
          r_duty_pend[i] <= bus.duty_in[i*CNT_W +: CNT_W];
        end
      end

      // Non-blocking copy: a cfg_load landing on the wrap cycle still
      // applies the previous pending value here.
      if (w_wrap || !bus.en) begin
        r_period_act <= r_period_pend;
        r_dt_act     <= r_dt_pend;
        for (int i = 0; i < N_CH; i++) begin
          r_duty_act[i] <= r_duty_pend[i];
        end
      end

      if (!bus.en || w_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      r_period_end <= w_wrap;
      r_raw_q      <= w_raw_q_next;
      r_pwm_h      <= w_h_next;
      r_pwm_l      <= w_l_next;
      for (int i = 0; i < N_CH; i++) begin
        r_dtc[i] <= w_dtc_next[i];
      end
    end
  end

  assign bus.pwm_h      = r_pwm_h;
  assign bus.pwm_l      = r_pwm_l;
  assign bus.period_end = r_period_end;

endmodule
